// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, branch codes and default parameters for the MEM stage
package mem_pkg;
   typedef enum logic {IDLE, ACCESS} state_t;
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ = 2'b01;
   localparam logic [1:0] BR_BNE = 2'b10;
   localparam int TIMEOUT_CYC_DEF = 255;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts enabled cycles and flags the cycle in which the limit is reached
module mem_watchdog import mem_pkg::*; #(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYC + 1);
   logic [W-1:0] cnt;
   // cnt holds the number of earlier cycles, so the Nth enabled cycle sees N-1
   assign expired = enable & (cnt == W'(TIMEOUT_CYC - 1));
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= clear ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with stalling data-memory handshake, watchdog and branch resolve
module mem_access import mem_pkg::*; #(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:2] fourPC,
   input  logic [1:0]  jump,
   input  logic [1:0]  branch,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [1:0]  memToReg,
   input  logic        regWrite,
   input  logic [31:0] beqInstruction,
   input  logic        zero,
   input  logic [31:0] aluResult,
   input  logic [31:0] readData2,
   input  logic [5:0]  writeDataReg,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:2] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        stall,
   output logic        pcSrc,
   output logic [31:0] branchTarget,
   output logic        bus_err,
   output logic        out_valid,
   output logic        out_regWrite,
   output logic [1:0]  out_memToReg,
   output logic [31:0] out_aluResult,
   output logic [31:0] out_readData,
   output logic [5:0]  out_writeDataReg,
   output logic [31:2] out_fourPC,
   output logic [1:0]  out_jump
);
   state_t state, state_nx;
   logic accept_mem, accept_alu, done, timeout;
   logic req_load, req_reg_write;
   logic [1:0] req_mem_to_reg, req_jump;
   logic [31:0] req_alu_result;
   logic [5:0] req_write_reg;
   logic [31:2] req_four_pc;
   assign branchTarget = beqInstruction;
   always_comb begin
      accept_mem = (state == IDLE) & in_valid & (memRead | memWrite);
      accept_alu = (state == IDLE) & in_valid & ~(memRead | memWrite);
      done = (state == ACCESS) & (dm_ack | timeout);
      stall = accept_mem | ((state == ACCESS) & ~dm_ack & ~timeout);
      pcSrc = in_valid & (state == IDLE) & (((branch == BR_BEQ) & zero) | ((branch == BR_BNE) & ~zero));
      state_nx = accept_mem ? ACCESS : done ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
      .clk(clk), .rst(rst), .clear((state != ACCESS) | done),
      .enable(state == ACCESS), .expired(timeout)
   );
   // a simultaneous read+write is a write, so only a pure read counts as a load
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {dm_req, dm_we, dm_addr, dm_wdata, bus_err} <= '0;
         {req_load, req_reg_write, req_mem_to_reg, req_jump} <= '0;
         {req_alu_result, req_write_reg, req_four_pc} <= '0;
      end else begin
         if (accept_mem) begin
            dm_req <= 1'b1;
            dm_we <= memWrite;
            dm_addr <= aluResult[31:2];
            dm_wdata <= readData2;
            req_load <= memRead & ~memWrite;
            req_reg_write <= regWrite;
            req_mem_to_reg <= memToReg;
            req_jump <= jump;
            req_alu_result <= aluResult;
            req_write_reg <= writeDataReg;
            req_four_pc <= fourPC;
         end else if (done) begin
            dm_req <= 1'b0;
            dm_we <= 1'b0;
         end
         bus_err <= bus_err | (done & ~dm_ack);
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {out_valid, out_regWrite, out_memToReg, out_aluResult} <= '0;
         {out_readData, out_writeDataReg, out_fourPC, out_jump} <= '0;
      end else if (accept_alu) begin
         out_valid <= 1'b1;
         out_regWrite <= regWrite;
         out_memToReg <= memToReg;
         out_aluResult <= aluResult;
         out_readData <= '0;
         out_writeDataReg <= writeDataReg;
         out_fourPC <= fourPC;
         out_jump <= jump;
      end else if (done) begin
         out_valid <= 1'b1;
         out_regWrite <= req_reg_write;
         out_memToReg <= req_mem_to_reg;
         out_aluResult <= req_alu_result;
         out_readData <= ~req_load ? '0 : dm_ack ? dm_rdata : ERR_DATA;
         out_writeDataReg <= req_write_reg;
         out_fourPC <= req_four_pc;
         out_jump <= req_jump;
      end else begin
         out_valid <= 1'b0;
         out_regWrite <= 1'b0;
      end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for the mem_access MEM stage
module tb_mem_access;
   logic clk, rst, in_valid, memRead, memWrite, regWrite, zero, dm_ack;
   logic [31:2] fourPC, dm_addr, out_fourPC;
   logic [1:0] jump, branch, memToReg, out_memToReg, out_jump;
   logic [31:0] beqInstruction, aluResult, readData2, dm_rdata, dm_wdata;
   logic [31:0] branchTarget, out_aluResult, out_readData;
   logic [5:0] writeDataReg, out_writeDataReg;
   logic dm_req, dm_we, stall, pcSrc, bus_err, out_valid, out_regWrite;
   int total = 0, bad = 0, n, stalls;

   mem_access dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .fourPC(fourPC), .jump(jump),
      .branch(branch), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
      .regWrite(regWrite), .beqInstruction(beqInstruction), .zero(zero),
      .aluResult(aluResult), .readData2(readData2), .writeDataReg(writeDataReg),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .pcSrc(pcSrc),
      .branchTarget(branchTarget), .bus_err(bus_err), .out_valid(out_valid),
      .out_regWrite(out_regWrite), .out_memToReg(out_memToReg),
      .out_aluResult(out_aluResult), .out_readData(out_readData),
      .out_writeDataReg(out_writeDataReg), .out_fourPC(out_fourPC), .out_jump(out_jump)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      {in_valid, memRead, memWrite, regWrite, zero, dm_ack} = '0;
      {fourPC, jump, branch, memToReg, beqInstruction} = '0;
      {aluResult, readData2, dm_rdata, writeDataReg} = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      clr_in();
      rst = 0;
      tick(); tick();
      chk("rst_dm_req", dm_req, 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_stall", stall, 0);
      rst = 1;
      tick();
      // ALU op
      in_valid = 1; regWrite = 1; aluResult = 32'h10; writeDataReg = 6'd5; fourPC = 30'h11; jump = 2'b10;
      #1 chk("alu_stall", stall, 0);
      tick();
      chk("alu_valid", out_valid, 1);
      chk("alu_result", out_aluResult, 32'h10);
      chk("alu_regwr", out_regWrite, 1);
      chk("alu_wreg", out_writeDataReg, 5);
      chk("alu_fourpc", out_fourPC, 32'h11);
      chk("alu_jump", out_jump, 2);
      chk("alu_rdata", out_readData, 0);
      clr_in();
      tick();
      chk("bubble_valid", out_valid, 0);
      chk("bubble_regwr", out_regWrite, 0);
      // load with ack in the 4th ACCESS cycle
      in_valid = 1; memRead = 1; regWrite = 1; aluResult = 32'h100; writeDataReg = 6'd9;
      stalls = 0;
      #1 chk("ld_dm_req0", dm_req, 0);
      stalls += stall;
      tick();
      chk("ld_dm_req", dm_req, 1);
      chk("ld_dm_addr", dm_addr, 32'h40);
      chk("ld_dm_we", dm_we, 0);
      chk("ld_out_valid", out_valid, 0);
      stalls += stall;
      tick();
      branch = 2'b01; zero = 1;
      #1 chk("ld_pcsrc_access", pcSrc, 0);
      stalls += stall;
      tick();
      branch = 0; zero = 0;
      chk("ld_addr_stable", dm_addr, 32'h40);
      stalls += stall;
      tick();
      dm_ack = 1; dm_rdata = 32'hCAFE0001;
      #1 chk("ld_ack_stall", stall, 0);
      chk("ld_stall_cycles", stalls, 4);
      tick();
      clr_in();
      chk("ld_valid", out_valid, 1);
      chk("ld_rdata", out_readData, 32'hCAFE0001);
      chk("ld_alu", out_aluResult, 32'h100);
      chk("ld_wreg", out_writeDataReg, 9);
      chk("ld_req_drop", dm_req, 0);
      // store with read also high: behaves as a write
      in_valid = 1; memRead = 1; memWrite = 1; readData2 = 32'h55; aluResult = 32'h8;
      tick();
      chk("st_dm_we", dm_we, 1);
      chk("st_wdata", dm_wdata, 32'h55);
      chk("st_addr", dm_addr, 32'h2);
      dm_ack = 1; dm_rdata = 32'h1234_5678;
      #1 chk("st_stall", stall, 0);
      tick();
      clr_in();
      chk("st_valid", out_valid, 1);
      chk("st_rdata", out_readData, 0);
      chk("st_we_drop", dm_we, 0);
      // stray ack in IDLE
      dm_ack = 1; dm_rdata = 32'hFFFF_FFFF;
      tick();
      dm_ack = 0;
      chk("idle_ack_valid", out_valid, 0);
      chk("idle_ack_req", dm_req, 0);
      // branch resolution
      in_valid = 1; branch = 2'b01; zero = 1; beqInstruction = 32'h400;
      #1 chk("beq_taken", pcSrc, 1);
      chk("beq_target", branchTarget, 32'h400);
      zero = 0;
      #1 chk("beq_not", pcSrc, 0);
      branch = 2'b10;
      #1 chk("bne_taken", pcSrc, 1);
      branch = 2'b11;
      #1 chk("br11_none", pcSrc, 0);
      branch = 2'b10; in_valid = 0;
      #1 chk("bne_invalid", pcSrc, 0);
      clr_in();
      tick();
      // load with no ack: watchdog
      in_valid = 1; memRead = 1; aluResult = 32'h20;
      tick();
      n = 0;
      do begin
         n++;
         if (!stall) break;
         tick();
      end while (n < 400);
      chk("to_cycles", n, 255);
      clr_in();
      tick();
      chk("to_valid", out_valid, 1);
      chk("to_rdata", out_readData, 32'hDEAD_BEEF);
      chk("to_bus_err", bus_err, 1);
      tick(); tick();
      chk("to_bus_err_sticky", bus_err, 1);
      // reset in ACCESS cycle 2
      in_valid = 1; memRead = 1; aluResult = 32'h44;
      tick(); tick();
      chk("mid_req", dm_req, 1);
      rst = 0; memRead = 0; branch = 2'b01; zero = 1;
      #1 chk("mid_rst_req", dm_req, 0);
      chk("mid_rst_idle", pcSrc, 1);
      chk("mid_rst_bus_err", bus_err, 0);
      chk("mid_rst_addr", dm_addr, 0);
      clr_in();
      tick();
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_no_pulse", out_valid, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
